// File: rtl/grf_sb.sv
// Decode-stage register file: one WB write port, NUM_RD combinational read ports,
// same-cycle write bypass and a per-register pending-write scoreboard for hazard detection.
module grf_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [31:0]              pc,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        busy,
    output logic                     busy_any
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              wr_ok;
    logic              set_ok;

    // pc only identifies the producer in the simulation trace; it carries no state.
    logic unused_pc;
    assign unused_pc = ^pc;

    // Inputs are ignored while reset is held so the bypass path cannot leak wd.
    assign wr_ok  = reset && we && !((ZERO_REG != 0) && (wa == '0));
    assign set_ok = reset && set_en && !((ZERO_REG != 0) && (set_addr == '0));

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_ok) begin
            mem_d[wa]  = wd;
            pend_d[wa] = 1'b0;
        end
        // Applied after the clear: a newer producer issued this cycle stays outstanding.
        if (set_ok) begin
            pend_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              is_zero;
            logic              hit;
            logic              set_hit;

            assign addr    = ra[k*ADDR_W +: ADDR_W];
            assign is_zero = (ZERO_REG != 0) && (addr == '0);
            assign hit     = (BYPASS != 0) && wr_ok && (wa == addr);
            assign set_hit = set_en && (set_addr == addr);

            assign rd[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                            hit     ? wd : mem_q[addr];
            assign busy[k] = is_zero           ? 1'b0 :
                             (hit && !set_hit) ? 1'b0 : pend_q[addr];
        end
    endgenerate

    assign busy_any = |pend_q;

endmodule

// File: tb/tb_grf_sb.sv
// Directed bench for grf_sb: a default-parameter instance plus a 4-port, 16-bit,
// no-bypass instance; expected values are queued with each step and checked after settling.
module tb_grf_sb;

    localparam int S_A_RD0     = 0;
    localparam int S_A_RD1     = 1;
    localparam int S_A_BUSY0   = 2;
    localparam int S_A_BUSY1   = 3;
    localparam int S_A_BUSYANY = 4;
    localparam int S_B_RD0     = 5;
    localparam int S_B_BUSYANY = 9;
    localparam int S_B_BUSY    = 10;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_we = 1'b0;
    logic [4:0]  a_wa = '0;
    logic [31:0] a_wd = '0;
    logic [31:0] a_pc = '0;
    logic        a_set_en = 1'b0;
    logic [4:0]  a_set_addr = '0;
    logic [9:0]  a_ra = '0;
    logic [63:0] a_rd;
    logic [1:0]  a_busy;
    logic        a_busy_any;

    logic        b_we = 1'b0;
    logic [3:0]  b_wa = '0;
    logic [15:0] b_wd = '0;
    logic [31:0] b_pc = '0;
    logic        b_set_en = 1'b0;
    logic [3:0]  b_set_addr = '0;
    logic [15:0] b_ra = '0;
    logic [63:0] b_rd;
    logic [3:0]  b_busy;
    logic        b_busy_any;

    always #5 clk = ~clk;

    grf_sb u_a (
        .clk(clk), .reset(rst_n), .we(a_we), .wa(a_wa), .wd(a_wd), .pc(a_pc),
        .set_en(a_set_en), .set_addr(a_set_addr), .ra(a_ra),
        .rd(a_rd), .busy(a_busy), .busy_any(a_busy_any)
    );

    grf_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) u_b (
        .clk(clk), .reset(rst_n), .we(b_we), .wa(b_wa), .wd(b_wd), .pc(b_pc),
        .set_en(b_set_en), .set_addr(b_set_addr), .ra(b_ra),
        .rd(b_rd), .busy(b_busy), .busy_any(b_busy_any)
    );

    // Write trace for the default instance; zero-register writes are suppressed.
    always @(posedge clk) begin
        if (rst_n && a_we && a_wa != 5'd0)
            $display("@%08h: $%2d <= %08h", a_pc, a_wa, a_wd);
    end

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_A_RD0:     observe = {32'd0, a_rd[31:0]};
            S_A_RD1:     observe = {32'd0, a_rd[63:32]};
            S_A_BUSY0:   observe = {63'd0, a_busy[0]};
            S_A_BUSY1:   observe = {63'd0, a_busy[1]};
            S_A_BUSYANY: observe = {63'd0, a_busy_any};
            5, 6, 7, 8:  observe = {48'd0, b_rd[16*(sel-S_B_RD0) +: 16]};
            S_B_BUSYANY: observe = {63'd0, b_busy_any};
            S_B_BUSY:    observe = {60'd0, b_busy};
            default:     observe = 'x;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        a_ra = {5'd5, 5'd8};
        b_ra = {4'd2, 4'd2, 4'd2, 4'd2};
        #2;
        push("rst_rd0", S_A_RD0, 64'h0);
        push("rst_rd1", S_A_RD1, 64'h0);
        push("rst_busy0", S_A_BUSY0, 64'h0);
        push("rst_busy_any", S_A_BUSYANY, 64'h0);
        push("rst_b_busy_any", S_B_BUSYANY, 64'h0);
        drain();
        @(negedge clk) rst_n = 1'b1;

        // Write with same-cycle bypass
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd8; a_wd = 32'hDEADBEEF; a_pc = 32'h3000;
        #1;
        push("byp_rd0", S_A_RD0, 64'hDEADBEEF);
        push("byp_rd1_other", S_A_RD1, 64'h0);
        push("byp_busy0", S_A_BUSY0, 64'h0);
        drain();
        @(negedge clk);
        a_we = 1'b0;
        #1;
        push("stored_rd0", S_A_RD0, 64'hDEADBEEF);
        drain();

        // No-bypass instance, all four ports on one register
        @(negedge clk);
        b_we = 1'b1; b_wa = 4'd2; b_wd = 16'hA5A5;
        #1;
        for (int p = 0; p < 4; p++) push($sformatf("nobyp_rd%0d", p), S_B_RD0 + p, 64'h0);
        drain();
        @(negedge clk);
        b_we = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) push($sformatf("multi_rd%0d", p), S_B_RD0 + p, 64'hA5A5);
        push("multi_busy", S_B_BUSY, 64'h0);
        drain();

        // Zero register ignores write and busy-set
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF; a_pc = 32'h3004;
        a_set_en = 1'b1; a_set_addr = 5'd0; a_ra = {5'd8, 5'd0};
        #1;
        push("zero_rd0_same", S_A_RD0, 64'h0);
        push("zero_busy0_same", S_A_BUSY0, 64'h0);
        drain();
        @(negedge clk);
        a_we = 1'b0; a_set_en = 1'b0;
        #1;
        push("zero_rd0_after", S_A_RD0, 64'h0);
        push("zero_busy0_after", S_A_BUSY0, 64'h0);
        push("zero_busy_any", S_A_BUSYANY, 64'h0);
        drain();

        // Scoreboard set then WB clear
        @(negedge clk);
        a_set_en = 1'b1; a_set_addr = 5'd3; a_ra = {5'd8, 5'd3};
        #1;
        push("set_busy0_same", S_A_BUSY0, 64'h0);
        drain();
        @(negedge clk);
        a_set_en = 1'b0;
        #1;
        push("set_busy0_next", S_A_BUSY0, 64'h1);
        push("set_busy_any", S_A_BUSYANY, 64'h1);
        drain();
        @(negedge clk);
        a_ra = {5'd3, 5'd3};
        #1;
        push("set_busy1_hold", S_A_BUSY1, 64'h1);
        drain();
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h33; a_pc = 32'h3010;
        #1;
        push("wb_busy0_byp", S_A_BUSY0, 64'h0);
        push("wb_rd1_byp", S_A_RD1, 64'h33);
        push("wb_busy_any_pre", S_A_BUSYANY, 64'h1);
        drain();
        @(negedge clk);
        a_we = 1'b0;
        #1;
        push("wb_busy0_after", S_A_BUSY0, 64'h0);
        push("wb_busy_any_after", S_A_BUSYANY, 64'h0);
        push("wb_rd0_after", S_A_RD0, 64'h33);
        drain();

        // Set and write to the same register: set wins
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h55; a_pc = 32'h3020;
        a_set_en = 1'b1; a_set_addr = 5'd7; a_ra = {5'd8, 5'd7};
        #1;
        push("coll_rd0_same", S_A_RD0, 64'h55);
        push("coll_busy0_same", S_A_BUSY0, 64'h0);
        drain();
        @(negedge clk);
        a_we = 1'b0; a_set_en = 1'b0;
        #1;
        push("coll_rd0_after", S_A_RD0, 64'h55);
        push("coll_busy0_after", S_A_BUSY0, 64'h1);
        push("coll_busy_any", S_A_BUSYANY, 64'h1);
        drain();

        // Reset dropped between edges clears data and pending at once
        @(negedge clk);
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'h1234; a_pc = 32'h3030;
        a_ra = {5'd5, 5'd7};
        #1;
        push("mid_rd1_byp", S_A_RD1, 64'h1234);
        drain();
        @(negedge clk);
        a_we = 1'b0;
        #1;
        push("mid_rd1_stored", S_A_RD1, 64'h1234);
        drain();
        #1 rst_n = 1'b0;
        #1;
        push("mid_rst_rd1", S_A_RD1, 64'h0);
        push("mid_rst_rd0", S_A_RD0, 64'h0);
        push("mid_rst_busy0", S_A_BUSY0, 64'h0);
        push("mid_rst_busy_any", S_A_BUSYANY, 64'h0);
        push("mid_rst_b_rd0", S_B_RD0, 64'h0);
        drain();
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h99;
        a_ra = {5'd9, 5'd7};
        #1;
        push("rst_ignores_we", S_A_RD1, 64'h0);
        drain();
        @(negedge clk);
        a_we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        push("post_rst_rd0", S_A_RD0, 64'h0);
        push("post_rst_rd1", S_A_RD1, 64'h0);
        push("post_rst_busy_any", S_A_BUSYANY, 64'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
